// File: rtl/pdu_ctrl.sv
// Debug/control unit for the single-cycle CPU: gates execution (run, single-step,
// PC breakpoint), owns the LED/segment/switch IO bus and counts retired instructions.
module pdu_ctrl #(
  parameter int SW_W  = 16,
  parameter int BRK_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             valid,
  input  logic [SW_W-1:0]  sw,
  input  logic             brk_en,
  input  logic [BRK_W-1:0] brk_pc,
  input  logic [BRK_W-1:0] pc,
  output logic             cpu_en,
  input  logic [7:0]       io_addr,
  input  logic [31:0]      io_dout,
  input  logic             io_we,
  output logic [31:0]      io_din,
  output logic [SW_W-1:0]  led,
  output logic [31:0]      seg,
  output logic             in_rdy,
  output logic [31:0]      instr_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2,
    BRK  = 2'd3
  } state_t;

  state_t          cur_state;
  logic            step_q;
  logic            valid_q;
  logic [SW_W-1:0] in_data;
  logic [31:0]     in_data_ext;
  logic            step_edge;
  logic            valid_edge;
  logic            hit;
  logic            io_wr;
  logic            ack;

  // A breakpoint hit suppresses the enable, so the instruction at brk_pc waits for a step.
  always_comb begin
    step_edge   = step & ~step_q;
    valid_edge  = valid & ~valid_q;
    hit         = brk_en & (pc == brk_pc);
    cpu_en      = (cur_state == STEP) | ((cur_state == RUN) & run & ~hit);
    io_wr       = io_we & cpu_en;
    ack         = io_wr & (io_addr == 8'h08);
    in_data_ext = '0;
    in_data_ext[SW_W-1:0] = in_data;
  end

  always_comb begin
    io_din = '0;
    case (io_addr)
      8'h08:   io_din = {31'b0, in_rdy};
      8'h0C:   io_din = in_data_ext;
      default: io_din = '0;
    endcase
  end

  // Edge registers follow the buttons during reset, so a button held through reset
  // (still 0 when released) never produces an edge on the way out.
  always_ff @(posedge clk) begin
    step_q  <= step;
    valid_q <= valid;
    if (rst) begin
      cur_state <= IDLE;
    end else begin
      unique case (cur_state)
        IDLE, BRK: if (step_edge) cur_state <= STEP;
        STEP:      cur_state <= run ? RUN : IDLE;
        RUN: begin
          if (hit)       cur_state <= BRK;
          else if (!run) cur_state <= IDLE;
        end
      endcase
    end
  end

  // A fresh switch latch outranks a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= '0;
      seg       <= '0;
      in_rdy    <= 1'b0;
      in_data   <= '0;
      instr_cnt <= '0;
    end else begin
      if (cpu_en) instr_cnt <= instr_cnt + 32'd1;
      if (io_wr) begin
        case (io_addr)
          8'h00:   led <= io_dout[SW_W-1:0];
          8'h04:   seg <= io_dout;
          default: ;
        endcase
      end
      if (valid_edge) begin
        in_data <= sw;
        in_rdy  <= 1'b1;
      end else if (ack) begin
        in_rdy  <= 1'b0;
      end
    end
  end

  assign state = cur_state;

endmodule
